// File: rtl/wb_stream_fifo.sv
// Wishbone pipelined write-stream FIFO: buffers upstream writes and replays them
// downstream, limiting how many downstream writes may await acknowledge at once.
module wb_stream_fifo #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 4,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int ALMOST_FULL_LEVEL = (2**ADDR_WIDTH) - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_cyc_i,
  input  logic                  s_stb_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic                  s_stall_o,
  output logic                  s_ack_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  output logic [DATA_WIDTH-1:0] m_dat_o,
  input  logic                  m_stall_i,
  input  logic                  m_ack_i,
  input  logic                  m_err_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  err_o
);
  localparam int                  DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C      = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [3:0]          MAX_OUT_C = 4'(MAX_OUTSTANDING);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [3:0]            outst_q, outst_d;
  logic                  ack_q;
  logic                  err_q, err_d;
  logic                  request, push, pop, complete;

  always_comb begin
    request       = s_cyc_i & s_stb_i;
    full_o        = (count_q == DEPTH_C);
    empty_o       = (count_q == '0);
    almost_full_o = (count_q >= AF_C);
    // A full FIFO refuses the push even if a pop frees a slot this same cycle.
    push          = request & ~full_o;
    s_stall_o     = request & full_o;
    m_stb_o       = ~empty_o & (outst_q < MAX_OUT_C);
    m_dat_o       = mem_q[rd_ptr_q];
    pop           = m_stb_o & ~m_stall_i;
    // Completions with nothing outstanding are strays and must not underflow.
    complete      = (m_ack_i | m_err_i) & (outst_q != '0);
    m_cyc_o       = m_stb_o | (outst_q != '0);

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    outst_d = outst_q;
    case ({pop, complete})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    err_d = err_q | (m_err_i & (outst_q != '0));
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      ack_q    <= push;
      err_q    <= err_d;
    end
  end

  assign count_o = count_q;
  assign s_ack_o = ack_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_wb_stream_fifo.sv
// Bench for wb_stream_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_wb_stream_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MAXO  = 4;
  localparam int AFL   = 14;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          s_cyc_i = 1'b0, s_stb_i = 1'b0;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_stall_o, s_ack_o, m_cyc_o, m_stb_o;
  logic [DW-1:0] m_dat_o;
  logic          m_stall_i = 1'b0, m_ack_i = 1'b0, m_err_i = 1'b0;
  logic [AW:0]   count_o;
  logic          full_o, empty_o, almost_full_o, err_o;

  wb_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO),
                   .ALMOST_FULL_LEVEL(AFL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i),
    .s_dat_i(s_dat_i), .s_stall_o(s_stall_o), .s_ack_o(s_ack_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_o(m_dat_o),
    .m_stall_i(m_stall_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .err_o(err_o));

  initial forever #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mq[$];
  int  m_out = 0;
  bit  m_err = 0, m_ack = 0, mdl_valid = 0;
  bit  mdl_pop_edge = 0, mdl_rst_edge = 0;
  int  cyc = 0;

  initial forever begin : model
    bit req, push, stb, pop, comp;
    @(posedge clk_i);
    cyc++;
    mdl_pop_edge = 0;
    mdl_rst_edge = 0;
    if (rst_i) begin
      mq.delete();
      m_out = 0; m_err = 0; m_ack = 0;
      mdl_valid = 1; mdl_rst_edge = 1;
    end else if (mdl_valid) begin
      req  = s_cyc_i && s_stb_i;
      push = req && (mq.size() < DEPTH);
      stb  = (mq.size() != 0) && (m_out < MAXO);
      pop  = stb && !m_stall_i;
      comp = (m_ack_i || m_err_i) && (m_out > 0);
      if (m_err_i && m_out > 0) m_err = 1;
      m_out = m_out + int'(pop) - int'(comp);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(s_dat_i);
      m_ack = push;
      mdl_pop_edge = pop;
    end
  end

  initial forever begin : compare
    bit exp_stb;
    @(negedge clk_i);
    if (mdl_valid) begin
      exp_stb = (mq.size() != 0) && (m_out < MAXO);
      chk("count_o", 32'(count_o), 32'(mq.size()));
      chk("full_o", 32'(full_o), 32'(mq.size() == DEPTH));
      chk("empty_o", 32'(empty_o), 32'(mq.size() == 0));
      chk("almost_full_o", 32'(almost_full_o), 32'(mq.size() >= AFL));
      chk("s_stall_o", 32'(s_stall_o), 32'(s_cyc_i && s_stb_i && mq.size() == DEPTH));
      chk("s_ack_o", 32'(s_ack_o), 32'(m_ack));
      chk("m_stb_o", 32'(m_stb_o), 32'(exp_stb));
      chk("m_cyc_o", 32'(m_cyc_o), 32'(exp_stb || m_out != 0));
      chk("err_o", 32'(err_o), 32'(m_err));
      if (exp_stb) chk("m_dat_o", 32'(m_dat_o), 32'(mq[0]));
    end
  end

  // ---------------- downstream responder ----------------
  int pend[$];
  int ack_delay = 1, comp_num = 0, err_at = 0;
  bit ack_en = 1, rand_mode = 0, force_ack = 0;

  initial forever begin : responder
    bit give;
    @(posedge clk_i);
    #2;
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    if (mdl_rst_edge) begin
      pend.delete();
    end else begin
      if (mdl_pop_edge && ack_en)
        pend.push_back(cyc + (rand_mode ? int'($urandom_range(1, 4)) : ack_delay));
      give = (pend.size() != 0) && (pend[0] <= cyc + 1);
      if (give) begin
        void'(pend.pop_front());
        comp_num++;
        if (comp_num == err_at || (rand_mode && $urandom_range(0, 31) == 0))
          m_err_i = 1'b1;
        else
          m_ack_i = 1'b1;
      end else if (rand_mode && pend.size() == 0 && $urandom_range(0, 15) == 0) begin
        m_ack_i = 1'b1;
      end
    end
    if (force_ack) m_ack_i = 1'b1;
  end

  // ---------------- pop recorder ----------------
  logic [DW-1:0] dq[$];
  bit rec_en = 0, seen_ack = 0;
  int pops_before = 0;

  initial forever begin : recorder
    @(negedge clk_i);
    if (rec_en) begin
      if (m_ack_i) seen_ack = 1;
      if (m_stb_o && !m_stall_i) begin
        dq.push_back(m_dat_o);
        if (!seen_ack) pops_before++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic req(input logic [DW-1:0] d);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_dat_i = d;
  endtask

  task automatic drain(input string nm);
    int k;
    idle();
    m_stall_i = 1'b0;
    for (k = 0; k < 300 && !(mq.size() == 0 && m_out == 0); k++) tick();
    if (k == 300) begin
      checks++; errors++;
      $display("FAIL %s: drain timeout, model count %0d outstanding %0d", nm, mq.size(), m_out);
    end
    @(negedge clk_i);
    chk({nm, "_count"}, 32'(count_o), 32'd0);
    chk({nm, "_cyc"}, 32'(m_cyc_o), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    tick(); tick();
    rst_i = 1'b0;

    // Single word: ack and strobe one cycle after push, cycle drops by cycle 3.
    ack_delay = 1;
    req(8'hA5);
    tick(); idle();
    @(negedge clk_i);
    chk("single_ack", 32'(s_ack_o), 32'd1);
    chk("single_stb", 32'(m_stb_o), 32'd1);
    chk("single_dat", 32'(m_dat_o), 32'hA5);
    tick(); tick();
    @(negedge clk_i);
    chk("single_cyc_low", 32'(m_cyc_o), 32'd0);

    // Fill with downstream stalled.
    m_stall_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req(8'(i));
      tick();
      if (i == 12) begin @(negedge clk_i); chk("af_at_13", 32'(almost_full_o), 32'd0); end
      if (i == 13) begin @(negedge clk_i); chk("af_at_14", 32'(almost_full_o), 32'd1); end
    end
    req(8'h10);
    @(negedge clk_i);
    chk("fill_stall", 32'(s_stall_o), 32'd1);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd16);
    tick();
    @(negedge clk_i);
    chk("fill_refused", 32'(count_o), 32'd16);
    tick(); idle();

    // Release the stall with acks 3 cycles late.
    ack_delay = 3;
    dq.delete(); seen_ack = 0; pops_before = 0; rec_en = 1;
    m_stall_i = 1'b0;
    drain("release");
    rec_en = 0;
    chk("pops_before_ack_le4", 32'(pops_before <= 4), 32'd1);
    chk("release_words", 32'(dq.size()), 32'd16);
    for (int i = 0; i < 16 && i < dq.size(); i++) chk("release_order", 32'(dq[i]), 32'(i));

    // Continuous streaming with 3 words pre-loaded.
    ack_delay = 1;
    m_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin req(8'(8'h20 + i)); tick(); end
    m_stall_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      req(8'(8'h30 + i));
      @(negedge clk_i);
      chk("stream_count", 32'(count_o), 32'd3);
      tick();
    end
    drain("stream");

    // Error on the second completion.
    err_at = comp_num + 2;
    m_stall_i = 1'b1;
    for (int i = 0; i < 6; i++) begin req(8'(8'h60 + i)); tick(); end
    idle();
    drain("errdrain");
    chk("err_sticky", 32'(err_o), 32'd1);
    err_at = 0;
    pulse_reset();
    @(negedge clk_i);
    chk("err_cleared", 32'(err_o), 32'd0);

    // Reset with count 5 and two writes outstanding, then a stray ack.
    tick();
    ack_en = 0;
    m_stall_i = 1'b1;
    for (int i = 0; i < 7; i++) begin req(8'(8'h80 + i)); tick(); end
    idle();
    m_stall_i = 1'b0;
    tick(); tick();
    m_stall_i = 1'b1;
    @(negedge clk_i);
    chk("pre_rst_count", 32'(count_o), 32'd5);
    chk("pre_rst_cyc", 32'(m_cyc_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_cyc", 32'(m_cyc_o), 32'd0);
    chk("rst_stb", 32'(m_stb_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    tick();
    rst_i = 1'b0;
    force_ack = 1;
    tick();
    force_ack = 0;
    tick();
    @(negedge clk_i);
    chk("stray_cyc", 32'(m_cyc_o), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin req(8'(8'h90 + i)); tick(); end
    idle();
    m_stall_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk_i);
    chk("cap_count", 32'(count_o), 32'd1);
    chk("cap_stb", 32'(m_stb_o), 32'd0);
    tick();
    ack_en = 1;
    pulse_reset();

    // Randomized traffic with one mid-run reset.
    rand_mode = 1;
    for (int i = 0; i < 800; i++) begin
      s_cyc_i   = ($urandom_range(0, 3) != 0);
      s_stb_i   = ($urandom_range(0, 2) != 0);
      s_dat_i   = 8'($urandom);
      m_stall_i = ($urandom_range(0, 3) == 0);
      rst_i     = (i == 400);
      tick();
    end
    rst_i = 1'b0;
    drain("rand");
    rand_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stream_fifo.md
WB_STREAM_FIFO -- requirements
Module: wb_stream_fifo

Interface
- REQ-001 Parameter DATA_WIDTH, default 8: width of each buffered word.
- REQ-002 Parameter ADDR_WIDTH, default 4: DEPTH = 2**ADDR_WIDTH entries.
- REQ-003 Parameter MAX_OUTSTANDING, default 4: maximum downstream writes accepted but not yet acked (1..15).
- REQ-004 Parameter ALMOST_FULL_LEVEL, default DEPTH-2: threshold for almost_full_o.
- REQ-005 clk_i  in  1  sole clock; all state changes on rising edge.
- REQ-006 rst_i  in  1  reset, synchronous, active-high.
- REQ-007 s_cyc_i, s_stb_i  in  1 each  upstream controller cycle and strobe.
- REQ-008 s_dat_i  in  DATA_WIDTH  upstream write data.
- REQ-009 s_stall_o, s_ack_o  out  1 each  upstream stall and acknowledge.
- REQ-010 m_cyc_o, m_stb_o  out  1 each  downstream cycle and strobe.
- REQ-011 m_dat_o  out  DATA_WIDTH  downstream write data.
- REQ-012 m_stall_i, m_ack_i, m_err_i  in  1 each  downstream stall, acknowledge, error.
- REQ-013 count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- REQ-014 full_o, empty_o, almost_full_o  out  1 each  occupancy flags.
- REQ-015 err_o  out  1  sticky flag: a downstream error has been seen.

Function
- REQ-016 Request = s_cyc_i & s_stb_i; push = request & !full_o; s_stall_o = request & full_o (combinational).
- REQ-017 On push, s_dat_i is written at the write pointer, and the pointer advances modulo DEPTH (natural wrap).
- REQ-018 s_ack_o shall be 1 exactly in the cycle after each push; otherwise 0.
- REQ-019 m_stb_o = !empty_o & (outstanding < MAX_OUTSTANDING) (combinational); m_dat_o = word at the read pointer (combinational read).
- REQ-020 pop = m_stb_o & !m_stall_i; on pop, the read pointer advances modulo DEPTH.
- REQ-021 While m_stb_o=1 and m_stall_i=1, m_dat_o shall hold stable and the read pointer shall not move.
- REQ-022 Outstanding counter: +1 on pop, -1 on completion (m_ack_i | m_err_i); both in the same cycle leave it unchanged.
- REQ-023 Completion while outstanding==0 shall be ignored; the counter shall never underflow.
- REQ-024 m_cyc_o = m_stb_o | (outstanding != 0); it drops in the cycle after the last completion if the FIFO is empty.
- REQ-025 count update: push only +1; pop only -1; push & pop in the same cycle, or neither, leaves count unchanged.
- REQ-026 full_o = (count==DEPTH); empty_o = (count==0); almost_full_o = (count >= ALMOST_FULL_LEVEL).
- REQ-027 When full, push shall be refused even if a pop occurs in the same cycle; the freed slot is usable the following cycle.
- REQ-028 When empty, a same-cycle push shall not produce m_stb_o; data appears on m_dat_o the following cycle (latency 1 from push to m_stb_o).
- REQ-029 err_o shall set on m_err_i while outstanding != 0 and hold until reset; an erroneous word shall not be retransmitted.
- REQ-030 Data order shall be preserved: words leave in push order with no loss or duplication.

Reset
- REQ-031 While rst_i=1 at a clock edge: pointers, count, outstanding=0; s_ack_o=0; err_o=0.
- REQ-032 During reset, with count=0 and outstanding=0, the combinational outputs follow: m_stb_o=0, m_cyc_o=0, empty_o=1, full_o=0.
- REQ-033 Reset mid-transfer shall discard buffered data and outstanding acks; acks arriving after reset are ignored per REQ-023.
- REQ-034 Buffer storage contents need not be cleared by reset.

Verification
- REQ-035 Single push of 0xA5 with m_stall_i=0 and m_ack_i one cycle after the pop -> s_ack_o high in cycle 1; m_stb_o with m_dat_o=0xA5 in cycle 1; m_cyc_o low by cycle 3.
- REQ-036 m_stall_i=1, push 16 words (0x00..0x0F) -> full_o=1 and count_o=16; 17th request sees s_stall_o=1; almost_full_o asserted from count 14.
- REQ-037 Release the stall after the fill, with acks delayed 3 cycles -> at most 4 pops before the first ack; all 16 words exit in order.
- REQ-038 Continuous push and pop for 40 cycles -> pointers wrap at least twice; count stays constant; order is preserved.
- REQ-039 m_err_i on the 2nd completion -> err_o=1 and stays 1; the remaining words still drain; rst_i clears err_o.
- REQ-040 Assert rst_i with count=5 and outstanding=2 -> all counts 0 and m_cyc_o=0; a following stray m_ack_i leaves outstanding at 0.
